// File: rtl/vga_text_pkg.sv
// ============================================================================
// Module  : vga_text_pkg
// Brief   : Shared text-screen geometry, address layout and arbiter states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_text_pkg;

  localparam int unsigned c_maxcol_default = 79;
  localparam int unsigned c_maxlin_default = 29;

  typedef struct packed {
    logic       rsvd;
    logic [4:0] lin;
    logic [6:0] col;
  } text_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  function automatic logic addr_in_bounds(input text_addr_t a,
                                          input logic [6:0] maxcol,
                                          input logic [4:0] maxlin);
    return !a.rsvd && (a.col <= maxcol) && (a.lin <= maxlin);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_clear_seq.sv
// ============================================================================
// Module  : vram_clear_seq
// Brief   : Raster-order line/column counter driving the screen clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_clear_seq
  import vga_text_pkg::*;
#(
  parameter int unsigned MAXCOL = c_maxcol_default,
  parameter int unsigned MAXLIN = c_maxlin_default
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_step,
  output logic [4:0] o_lin,
  output logic [6:0] o_col,
  output logic       o_last
);

  localparam logic [6:0] c_col_last = 7'(MAXCOL);
  localparam logic [4:0] c_lin_last = 5'(MAXLIN);

  logic [4:0] r_lin;
  logic [6:0] r_col;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lin <= 5'd0;
      r_col <= 7'd0;
    end else if (i_start) begin
      r_lin <= 5'd0;
      r_col <= 7'd0;
    end else if (i_step) begin
      if (r_col == c_col_last) begin
        r_col <= 7'd0;
        r_lin <= (r_lin == c_lin_last) ? 5'd0 : r_lin + 5'd1;
      end else begin
        r_col <= r_col + 7'd1;
      end
    end
  end

  assign o_lin  = r_lin;
  assign o_col  = r_col;
  assign o_last = (r_lin == c_lin_last) && (r_col == c_col_last);

endmodule

`default_nettype wire

// File: rtl/vram_write_arbiter.sv
// ============================================================================
// Module  : vram_write_arbiter
// Brief   : Round-robin arbiter for two VRAM writers plus a full-screen clear.
//           Optional: VRAM_ARB_BOUNDS_CHECK_EN drops out-of-screen requests.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_write_arbiter
  import vga_text_pkg::*;
#(
  parameter logic [7:0]  CLEAR_CHAR = 8'h20,
  parameter int unsigned MAXCOL     = c_maxcol_default,
  parameter int unsigned MAXLIN     = c_maxlin_default
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_t_valid,
  input  logic [12:0] i_t_addr,
  input  logic [7:0]  i_t_data,
  output logic        o_t_ready,
  input  logic        i_s_valid,
  input  logic [12:0] i_s_addr,
  input  logic [7:0]  i_s_data,
  output logic        o_s_ready,
  input  logic        i_clear,
  output logic [12:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_we,
  output logic        o_busy,
  output logic        o_clear_done
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  logic        r_prio_s;
  logic        w_t_grant;
  logic        w_s_grant;
  logic        w_start;
  logic        w_step;
  logic        w_clear_wr;
  logic        w_t_ok;
  logic        w_s_ok;
  logic [4:0]  w_lin;
  logic [6:0]  w_col;
  logic        w_last;
  text_addr_t  w_clr_addr;
  logic [12:0] r_address;
  logic [7:0]  r_data;
  logic        r_we;

  vram_clear_seq #(
    .MAXCOL (MAXCOL),
    .MAXLIN (MAXLIN)
  ) u_clear_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .i_step  (w_step),
    .o_lin   (w_lin),
    .o_col   (w_col),
    .o_last  (w_last)
  );

`ifdef VRAM_ARB_BOUNDS_CHECK_EN
  assign w_t_ok = addr_in_bounds(text_addr_t'(i_t_addr), 7'(MAXCOL), 5'(MAXLIN));
  assign w_s_ok = addr_in_bounds(text_addr_t'(i_s_addr), 7'(MAXCOL), 5'(MAXLIN));
`else
  assign w_t_ok = 1'b1;
  assign w_s_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A clear request pre-empts any request presented in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_t_grant   = 1'b0;
    w_s_grant   = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_clear_wr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clear) begin
          w_state_nxt = ST_CLEAR;
          w_start     = 1'b1;
        end else if (i_t_valid && (!i_s_valid || !r_prio_s)) begin
          w_t_grant = 1'b1;
        end else if (i_s_valid) begin
          w_s_grant = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_step     = 1'b1;
        w_clear_wr = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // r_prio_s set means the status writer wins the next tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio_s <= 1'b0;
    end else if (w_t_grant) begin
      r_prio_s <= 1'b1;
    end else if (w_s_grant) begin
      r_prio_s <= 1'b0;
    end
  end

  assign w_clr_addr = '{rsvd: 1'b0, lin: w_lin, col: w_col};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we      <= 1'b0;
      r_address <= 13'd0;
      r_data    <= 8'd0;
    end else begin
      r_we <= 1'b0;
      if (w_clear_wr) begin
        r_we      <= 1'b1;
        r_address <= w_clr_addr;
        r_data    <= CLEAR_CHAR;
      end else if (w_t_grant && w_t_ok) begin
        r_we      <= 1'b1;
        r_address <= i_t_addr;
        r_data    <= i_t_data;
      end else if (w_s_grant && w_s_ok) begin
        r_we      <= 1'b1;
        r_address <= i_s_addr;
        r_data    <= i_s_data;
      end
    end
  end

  assign o_t_ready    = w_t_grant;
  assign o_s_ready    = w_s_grant;
  assign o_we         = r_we;
  assign o_address    = r_address;
  assign o_data       = r_data;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_clear_done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_vram_write_arbiter.sv
// ============================================================================
// Module  : tb_vram_write_arbiter
// Brief   : Randomized scoreboard bench for vram_write_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vram_write_arbiter;

  localparam int c_cols  = 80;
  localparam int c_lines = 30;
  localparam int c_cells = c_cols * c_lines;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        t_valid, s_valid, clear;
  logic [12:0] t_addr, s_addr;
  logic [7:0]  t_data, s_data;
  logic        t_ready, s_ready, we, busy, clear_done;
  logic [12:0] address;
  logic [7:0]  data;

  always #5 clk = ~clk;

  vram_write_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_t_valid    (t_valid),
    .i_t_addr     (t_addr),
    .i_t_data     (t_data),
    .o_t_ready    (t_ready),
    .i_s_valid    (s_valid),
    .i_s_addr     (s_addr),
    .i_s_data     (s_data),
    .o_s_ready    (s_ready),
    .i_clear      (clear),
    .o_address    (address),
    .o_data       (data),
    .o_we         (we),
    .o_busy       (busy),
    .o_clear_done (clear_done)
  );

  typedef struct {
    int          cyc;
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t expq[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // Reference model: cycles still owned by the clear, and who won last (0 none, 1 T, 2 S).
  int  m_block    = 0;
  int  last_grant = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic on_screen(input logic [12:0] a);
`ifdef VRAM_ARB_BOUNDS_CHECK_EN
    int lin, col;
    lin = int'(a[11:7]);
    col = int'(a[6:0]);
    return (a[12] == 1'b0) && (lin < c_lines) && (col < c_cols);
`else
    return 1'b1;
`endif
  endfunction

  // Write-port monitor: every write must match the oldest expected entry in the same cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_write: cyc=%0d got none, required addr=%h data=%h at cyc %0d",
                 cyc, expq[0].a, expq[0].d, expq[0].cyc);
        void'(expq.pop_front());
      end
      if (we) begin
        total++;
        if (expq.size() == 0 || expq[0].cyc != cyc) begin
          bad++;
          $display("FAIL unexpected_write: cyc=%0d got addr=%h data=%h, required no write",
                   cyc, address, data);
        end else begin
          mon_e = expq.pop_front();
          if (address !== mon_e.a || data !== mon_e.d) begin
            bad++;
            $display("FAIL write_value: cyc=%0d got addr=%h data=%h, required addr=%h data=%h",
                     cyc, address, data, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: cyc=%0d got %h, required %h", name, cyc, got, exp);
    end
  endtask

  // Drives one cycle of stimulus (entered just after a rising edge) and checks the control outputs.
  task automatic step(input logic tv, input logic [12:0] ta, input logic [7:0] td,
                      input logic sv, input logic [12:0] sa, input logic [7:0] sd,
                      input logic clr);
    logic et, es, eb, ed;
    int   win;
    int   k;
    t_valid = tv; t_addr = ta; t_data = td;
    s_valid = sv; s_addr = sa; s_data = sd;
    clear   = clr;
    @(negedge clk);
    et = 1'b0; es = 1'b0;
    eb = (m_block > 0);
    ed = (m_block == 1);
    if (m_block > 0) begin
      m_block--;
    end else if (clr) begin
      k = 0;
      for (int l = 0; l < c_lines; l++) begin
        for (int c = 0; c < c_cols; c++) begin
          expq.push_back(wr_t'{cyc + 2 + k, 13'(l * 128 + c), 8'h20});
          k++;
        end
      end
      m_block = c_cells + 1;
    end else begin
      win = 0;
      if (tv && sv)  win = (last_grant == 1) ? 2 : 1;
      else if (tv)   win = 1;
      else if (sv)   win = 2;
      if (win == 1) begin
        et = 1'b1;
        last_grant = 1;
        if (on_screen(ta)) expq.push_back(wr_t'{cyc + 1, ta, td});
      end else if (win == 2) begin
        es = 1'b1;
        last_grant = 2;
        if (on_screen(sa)) expq.push_back(wr_t'{cyc + 1, sa, sd});
      end
    end
    check("ctl{t_rdy,s_rdy,busy,done}", {28'd0, t_ready, s_ready, busy, clear_done},
          {28'd0, et, es, eb, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 13'd0, 8'd0, 1'b0, 13'd0, 8'd0, 1'b0);
  endtask

  task automatic apply_reset();
    t_valid = 1'b0; s_valid = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_outputs{we,addr,data,busy,done,t_rdy,s_rdy}",
          {8'd0, we, address, data, busy, clear_done, t_ready, s_ready}, 32'd0);
    expq.delete();
    m_block    = 0;
    last_grant = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    t_valid = 1'b0; s_valid = 1'b0; clear = 1'b0;
    t_addr = '0; s_addr = '0; t_data = '0; s_data = '0;
    @(posedge clk);
    #1;
    apply_reset();

    // Both writers held: alternate T,S,T,S starting with T.
    step(1'b1, 13'h0101, 8'hA1, 1'b1, 13'h0202, 8'hB2, 1'b0);
    step(1'b1, 13'h0103, 8'hA3, 1'b1, 13'h0204, 8'hB4, 1'b0);
    step(1'b1, 13'h0105, 8'hA5, 1'b1, 13'h0206, 8'hB6, 1'b0);
    step(1'b1, 13'h0107, 8'hA7, 1'b1, 13'h0208, 8'hB8, 1'b0);
    idle(1);

    // Terminal write at lin 3, col 5.
    step(1'b1, 13'h0185, 8'h41, 1'b0, 13'd0, 8'd0, 1'b0);
    idle(1);

    // Column 80: dropped with bounds checking, written otherwise.
    step(1'b1, 13'h0050, 8'h5A, 1'b0, 13'd0, 8'd0, 1'b0);
    idle(2);

    // Clear with a pending terminal request, re-triggered at write 100.
    step(1'b1, 13'h0ECF, 8'h77, 1'b0, 13'd0, 8'd0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 13'h0ECF, 8'h77, 1'b0, 13'd0, 8'd0, 1'b0);
    step(1'b1, 13'h0ECF, 8'h77, 1'b0, 13'd0, 8'd0, 1'b1);
    for (int i = 0; i < c_cells + 5; i++) step(1'b1, 13'h0ECF, 8'h77, 1'b0, 13'd0, 8'd0, 1'b0);
    idle(2);

    // Clear aborted by reset at write 1000; priority returns to T afterwards.
    step(1'b0, 13'd0, 8'd0, 1'b0, 13'd0, 8'd0, 1'b1);
    idle(1000);
    apply_reset();
    step(1'b1, 13'h0011, 8'hC1, 1'b1, 13'h0022, 8'hD2, 1'b0);
    idle(10);

    // Randomized traffic from both writers.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 13'($urandom), 8'($urandom),
           1'($urandom), 13'($urandom), 8'($urandom), 1'b0);
    end
    idle(4);

    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
